// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost flags, flush and sticky error flags.
// Read data appears 1 cycle after read_en; writes are refused when full (overflow) and reads when empty (underflow).
module sync_fifo_param #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int AF_THRESH  = 14,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  flush,
   input  logic                  write_en,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  read_en,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AF_C    = AF_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0] AE_C    = AE_THRESH[ADDR_WIDTH:0];

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [ADDR_WIDTH-1:0] wr_ptr;
   logic [ADDR_WIDTH-1:0] rd_ptr;
   logic [ADDR_WIDTH:0]   count_nxt;
   logic                  wr_acc;
   logic                  rd_acc;

   assign wr_acc = write_en && !full;
   assign rd_acc = read_en && !empty;

   always_comb begin
      count_nxt = count;
      if (wr_acc && !rd_acc)
         count_nxt = count + 1'b1;
      else if (rd_acc && !wr_acc)
         count_nxt = count - 1'b1;
   end

   // Storage is never cleared; only the pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (!reset && !flush && wr_acc)
         mem[wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         almost_full  <= 1'b0;
         almost_empty <= 1'b1;
         data_valid   <= 1'b0;
         overflow     <= 1'b0;
         underflow    <= 1'b0;
         if (reset)
            data_out <= '0;
      end else begin
         if (wr_acc)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_acc) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
         end
         data_valid   <= rd_acc;
         count        <= count_nxt;
         // Flags follow the next count so they always agree with count.
         full         <= (count_nxt == DEPTH_C);
         empty        <= (count_nxt == '0);
         almost_full  <= (count_nxt >= AF_C);
         almost_empty <= (count_nxt <= AE_C);
         overflow     <= overflow  || (write_en && full);
         underflow    <= underflow || (read_en && empty);
      end
   end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Self-checking bench: queue model plus scoreboard for the default FIFO, hand checks for a 32-bit x 4 build.
module tb_sync_fifo_param;

   logic       clk = 1'b0;
   logic       reset, flush, write_en, read_en;
   logic [7:0] data_in, data_out;
   logic       data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
   logic [4:0] count;

   logic        r2, fl2, we2, re2;
   logic [31:0] din2, dout2;
   logic        dv2, full2, empty2, af2, ae2, ov2, uf2;
   logic [2:0]  count2;

   int checks = 0;
   int errors = 0;

   logic [7:0]  mq[$];
   logic [7:0]  sb[$];
   logic [31:0] q2[$];
   logic [7:0]  m_dout;
   bit          m_ov, m_uf;

   typedef struct {
      bit         fl;
      bit         we;
      logic [7:0] din;
      bit         re;
      int         cnt;
      bit         ov;
      bit         uf;
      bit         dv;
   } vec_t;
   vec_t tbl[13];

   always #5 clk = ~clk;

   sync_fifo_param dut (
      .clk(clk), .reset(reset), .flush(flush), .write_en(write_en), .data_in(data_in),
      .read_en(read_en), .data_out(data_out), .data_valid(data_valid), .full(full),
      .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
      .count(count), .overflow(overflow), .underflow(underflow)
   );

   sync_fifo_param #(.DATA_WIDTH(32), .ADDR_WIDTH(2), .AF_THRESH(3), .AE_THRESH(0)) dut2 (
      .clk(clk), .reset(r2), .flush(fl2), .write_en(we2), .data_in(din2),
      .read_en(re2), .data_out(dout2), .data_valid(dv2), .full(full2),
      .empty(empty2), .almost_full(af2), .almost_empty(ae2),
      .count(count2), .overflow(ov2), .underflow(uf2)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Drive one cycle from a negedge, advance the model, then check after the edge.
   task automatic step(input bit rs, input bit fl, input bit we, input logic [7:0] din, input bit re);
      bit ra;
      int n;
      reset = rs; flush = fl; write_en = we; data_in = din; read_en = re;
      ra = 1'b0;
      if (rs) begin
         mq.delete(); sb.delete(); m_ov = 0; m_uf = 0; m_dout = 8'h00;
      end else if (fl) begin
         mq.delete(); m_ov = 0; m_uf = 0;
      end else begin
         n = mq.size();
         if (we && n == 16) m_ov = 1;
         if (re && n == 0)  m_uf = 1;
         if (re && n > 0) begin
            ra = 1'b1;
            sb.push_back(mq.pop_front());
         end
         if (we && n < 16) mq.push_back(din);
      end
      @(posedge clk);
      @(negedge clk);
      n = mq.size();
      chk("count", count, n);
      chk("full", full, n == 16);
      chk("empty", empty, n == 0);
      chk("almost_full", almost_full, n >= 14);
      chk("almost_empty", almost_empty, n <= 2);
      chk("overflow", overflow, m_ov);
      chk("underflow", underflow, m_uf);
      chk("data_valid", data_valid, ra);
      if (data_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected_pop", 1, 0);
         end else begin
            m_dout = sb.pop_front();
            chk("sb_data_out", data_out, m_dout);
         end
      end else begin
         chk("data_out_hold", data_out, m_dout);
      end
   endtask

   initial begin
      tbl[0]  = '{1, 0, 8'h00, 0, 0, 0, 0, 0};
      tbl[1]  = '{0, 1, 8'hA5, 0, 1, 0, 0, 0};
      tbl[2]  = '{0, 0, 8'h00, 1, 0, 0, 0, 1};
      tbl[3]  = '{0, 1, 8'h11, 1, 1, 0, 1, 0};
      tbl[4]  = '{0, 1, 8'h22, 0, 2, 0, 1, 0};
      tbl[5]  = '{0, 1, 8'h33, 0, 3, 0, 1, 0};
      tbl[6]  = '{0, 1, 8'h44, 1, 3, 0, 1, 1};
      tbl[7]  = '{0, 0, 8'h00, 1, 2, 0, 1, 1};
      tbl[8]  = '{1, 1, 8'h55, 0, 0, 0, 0, 0};
      tbl[9]  = '{0, 0, 8'h00, 1, 0, 0, 1, 0};
      tbl[10] = '{1, 0, 8'h00, 0, 0, 0, 0, 0};
      tbl[11] = '{0, 1, 8'h66, 0, 1, 0, 0, 0};
      tbl[12] = '{0, 0, 8'h00, 1, 0, 0, 0, 1};

      reset = 1; flush = 0; write_en = 0; read_en = 0; data_in = 0;
      r2 = 1; fl2 = 0; we2 = 0; re2 = 0; din2 = 0;
      m_dout = 0; m_ov = 0; m_uf = 0;
      @(negedge clk);

      // Reset held two cycles with a write pending
      step(1, 0, 1, 8'hEE, 0);
      step(1, 0, 1, 8'hEE, 0);

      // Fill, overflow, drain in order, then underflow persistence
      for (int i = 1; i <= 16; i++) step(0, 0, 1, 8'(i), 0);
      chk("fill_full", full, 1);
      step(0, 0, 1, 8'h11, 0);
      chk("fill_overflow_count", count, 16);
      for (int i = 0; i < 16; i++) step(0, 0, 0, 8'h00, 1);
      chk("drain_last", data_out, 8'h10);
      step(0, 0, 0, 8'h00, 1);
      step(0, 0, 0, 8'h00, 0);
      chk("underflow_sticky", underflow, 1);

      // Table of mixed flush / write / read / simultaneous cases
      for (int i = 0; i < 13; i++) begin
         step(0, tbl[i].fl, tbl[i].we, tbl[i].din, tbl[i].re);
         chk($sformatf("tbl%0d_count", i), count, tbl[i].cnt);
         chk($sformatf("tbl%0d_overflow", i), overflow, tbl[i].ov);
         chk($sformatf("tbl%0d_underflow", i), underflow, tbl[i].uf);
         chk($sformatf("tbl%0d_valid", i), data_valid, tbl[i].dv);
      end

      // Count 5 with rd_ptr at 8, then 10 simultaneous ops wrapping rd_ptr 15->0
      for (int i = 0; i < 12; i++) step(0, 0, 1, 8'h80 + 8'(i), 0);
      for (int i = 0; i < 7; i++)  step(0, 0, 0, 8'h00, 1);
      for (int i = 0; i < 10; i++) begin
         step(0, 0, 1, 8'h90 + 8'(i), 1);
         chk("simul_count", count, 5);
      end
      for (int i = 0; i < 11; i++) step(0, 0, 1, 8'hA0 + 8'(i), 0);
      step(0, 0, 1, 8'hB0, 1);
      chk("full_simul_count", count, 15);
      chk("full_simul_overflow", overflow, 1);
      for (int i = 0; i < 15; i++) step(0, 0, 0, 8'h00, 1);

      // Flush at count 9 with overflow set and a write pending
      for (int i = 0; i < 9; i++) step(0, 0, 1, 8'hC0 + 8'(i), 0);
      step(0, 1, 1, 8'h77, 0);
      chk("flush_count", count, 0);
      chk("flush_overflow", overflow, 0);
      step(0, 0, 1, 8'hA5, 0);
      step(0, 0, 0, 8'h00, 1);
      chk("flush_readback", data_out, 8'hA5);
      step(0, 0, 0, 8'h00, 0);
      chk("sb_empty_at_end", sb.size(), 0);

      // 32-bit x 4 build with AF=3, AE=0
      @(negedge clk);
      r2 = 0;
      chk("p2_reset_count", count2, 0);
      chk("p2_reset_empty", empty2, 1);
      chk("p2_reset_ae", ae2, 1);
      for (int i = 0; i < 4; i++) begin
         we2 = 1; din2 = $urandom; q2.push_back(din2);
         @(posedge clk); @(negedge clk);
         chk("p2_w_count", count2, i + 1);
         chk("p2_w_af", af2, (i + 1) >= 3);
         chk("p2_w_full", full2, (i + 1) == 4);
         chk("p2_w_ae", ae2, 0);
      end
      din2 = 32'hDEADBEEF;
      @(posedge clk); @(negedge clk);
      chk("p2_overflow", ov2, 1);
      chk("p2_ovf_count", count2, 4);
      we2 = 0;
      for (int i = 0; i < 4; i++) begin
         re2 = 1;
         @(posedge clk); @(negedge clk);
         chk("p2_r_valid", dv2, 1);
         chk("p2_r_data", dout2, q2.pop_front());
         chk("p2_r_count", count2, 3 - i);
         chk("p2_r_ae", ae2, (3 - i) == 0);
         chk("p2_r_af", af2, (3 - i) >= 3);
      end
      re2 = 0;
      chk("p2_empty", empty2, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO, the successor to the fixed 8-bit sync_fifo. Generalised in data width and depth. Adds the following over the fixed version:
- occupancy count
- programmable almost-full and almost-empty flags
- read-data valid strobe
- synchronous flush
- sticky overflow/underflow error flags

Used as a general-purpose single-clock buffer between producer and consumer blocks.

Parameters:
DATA_WIDTH, 8, width of data_in/data_out in bits (>=1)
ADDR_WIDTH, 4, log2 of depth; DEPTH = 2**ADDR_WIDTH entries (>=1)
AF_THRESH, 14, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH; legal range 0 <= AE_THRESH < AF_THRESH <= DEPTH

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
flush  input  1  synchronous clear of FIFO contents and flags, active-high
write_en  input  1  write request
data_in  input  DATA_WIDTH  write data
read_en  input  1  read request
data_out  output  DATA_WIDTH  read data, registered
data_valid  output  1  high for one cycle when data_out holds a newly popped word
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Reset (reset=1 at a rising edge) sets:
  - count=0, empty=1, full=0, almost_empty=1, almost_full=0
  - data_out=0, data_valid=0, overflow=0, underflow=0
  - read and write pointers to 0
  - Memory contents are not cleared.
  - reset has priority over flush, write_en and read_en.
- Flush (flush=1, reset=0):
  - Same state as reset, except data_out holds its value.
  - Any write_en/read_en in the same cycle is ignored and sets no error flag.
- Write accept = write_en && !full. Data is stored at wr_ptr; wr_ptr increments modulo DEPTH.
- Read accept = read_en && !empty.
  - data_out <= mem[rd_ptr] at that edge, so data appears the cycle after read_en is sampled (1-cycle latency).
  - data_valid=1 for exactly that following cycle.
  - rd_ptr increments modulo DEPTH.
- No read accepted: data_valid=0 and data_out holds its last value.
- Pointers: ADDR_WIDTH-bit, wrap from DEPTH-1 to 0 with no gap.
- Count update per edge:
  - +1 on write-only accept
  - -1 on read-only accept
  - unchanged when both or neither are accepted
- Simultaneous read and write:
  - Empty: read rejected (underflow set), write accepted; count becomes 1. The new word is not bypassed to data_out.
  - Full: read accepted, write rejected (overflow set); count becomes DEPTH-1.
  - Otherwise both accepted, count unchanged.
- All status outputs (full, empty, almost_full, almost_empty) are registered. They are computed from the next count, so they always agree with count in the same cycle.
- overflow sets on write_en && full; underflow sets on read_en && empty. Both stay set until reset or flush.
- Read data ordering is strictly FIFO across any number of pointer wraps.

Test Plan:
- Reset: hold reset=1 for 2 cycles with write_en=1 -> count=0, empty=1, almost_empty=1, full=0, data_valid=0, no write stored.
- Fill/drain with defaults: write 0x01..0x10 on 16 consecutive cycles ->
  - almost_full rises when count reaches 14, full=1 at count 16.
  - 17th write sets overflow=1, count stays 16.
  - Then 16 reads -> data_out 0x01..0x10 in order, each one cycle after its read_en with data_valid=1.
  - almost_empty rises at count 2, empty=1 at count 0.
- Underflow: read_en=1 while empty -> underflow=1, data_valid=0, data_out unchanged. Underflow persists until flush.
- Simultaneous: with count=5, assert read_en and write_en together for 10 cycles -> count stays 5, data_valid each cycle, output order preserved across the rd_ptr wrap at 15->0. At full, simultaneous read+write -> count=15, overflow=1.
- Flush: with count=9 and overflow=1, pulse flush with write_en=1 -> next cycle count=0, empty=1, overflow=0, no word stored. A subsequent write of 0xA5 followed by a read returns 0xA5.
- Parameter sweep: DATA_WIDTH=32, ADDR_WIDTH=2, AF_THRESH=3, AE_THRESH=0 -> full after 4 writes, almost_full at 3, almost_empty only at count 0, 32-bit data intact.
